// File: rtl/fp_conv_arbiter.sv
// fp_conv_arbiter: round-robin sharing of one 13-bit float -> 8-bit
// sign-magnitude integer converter among N_REQ valid/ready requesters.
// One output register holds the last result with its requester ID.
// Saturating underflow/overflow event counters run alongside for status reads.
module fp_conv_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [13*N_REQ-1:0]  req_fp,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ID_W-1:0]      res_id,
    output logic [7:0]           res_int,
    output logic                 res_uf,
    output logic                 res_of,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     uf_cnt,
    output logic [CNT_W-1:0]     of_cnt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(N_REQ);

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               res_valid_q, res_valid_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;
    logic [7:0]         res_int_q, res_int_d;
    logic               res_uf_q, res_uf_d;
    logic               res_of_q, res_of_d;
    logic [CNT_W-1:0]   uf_cnt_q, uf_cnt_d;
    logic [CNT_W-1:0]   of_cnt_q, of_cnt_d;

    logic [2*N_REQ-1:0] req_dbl;
    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W:0]     idx_sum;
    logic [12:0]        grant_op;
    logic               accept_en;
    logic               xfer;

    logic               cv_sign;
    logic [3:0]         cv_exp;
    logic [7:0]         cv_frac;
    logic [7:0]         cv_shifted;
    logic [6:0]         cv_mag;
    logic               cv_uf;
    logic               cv_of;

    // Rotating the doubled request vector puts rr_ptr at bit 0, so the
    // lowest set bit is the next requester in round-robin order.
    assign req_dbl = {req_valid, req_valid} >> rr_ptr_q;

    // Round-robin search: first valid request at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx_sum     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_found && req_dbl[k]) begin
                grant_found = 1'b1;
                idx_sum     = {1'b0, rr_ptr_q} + k[PTR_W:0];
                if (idx_sum >= N_EXT) begin
                    idx_sum = idx_sum - N_EXT;
                end
                grant_idx = idx_sum[PTR_W-1:0];
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        grant_op = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                grant_op = req_fp[13*i +: 13];
            end
        end
    end

    // Shared converter; zero fraction wins over the exponent checks so that
    // a signed zero never raises a flag.
    always_comb begin
        cv_sign    = grant_op[12];
        cv_exp     = grant_op[11:8];
        cv_frac    = grant_op[7:0];
        cv_shifted = cv_frac >> (4'd8 - cv_exp);
        cv_mag     = '0;
        cv_uf      = 1'b0;
        cv_of      = 1'b0;
        if (cv_frac == 8'h00) begin
            cv_mag = '0;
        end else if (cv_exp == 4'd0) begin
            cv_uf  = 1'b1;
        end else if (cv_exp > 4'd7) begin
            cv_mag = 7'h7F;
            cv_of  = 1'b1;
        end else begin
            cv_mag = cv_shifted[6:0];
        end
    end

    assign accept_en = !res_valid_q || res_ready;
    assign xfer      = grant_found && accept_en && !reset;

    // One-hot ready to the granted requester only; nothing while in reset.
    always_comb begin
        req_ready = '0;
        if (grant_found && !reset) begin
            req_ready[grant_idx] = accept_en;
        end
    end

    // Next-state for the result register, pointer and saturating counters.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_int_d   = res_int_q;
        res_uf_d    = res_uf_q;
        res_of_d    = res_of_q;
        uf_cnt_d    = uf_cnt_q;
        of_cnt_d    = of_cnt_q;
        if (xfer) begin
            res_valid_d = 1'b1;
            res_id_d    = ID_W'(grant_idx);
            res_int_d   = {cv_sign, cv_mag};
            res_uf_d    = cv_uf;
            res_of_d    = cv_of;
            rr_ptr_d    = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            if (cv_uf && !(&uf_cnt_q)) begin
                uf_cnt_d = uf_cnt_q + 1'b1;
            end
            if (cv_of && !(&of_cnt_q)) begin
                of_cnt_d = of_cnt_q + 1'b1;
            end
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
        if (clr_cnt) begin
            uf_cnt_d = '0;
            of_cnt_d = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_int_q   <= '0;
            res_uf_q    <= 1'b0;
            res_of_q    <= 1'b0;
            uf_cnt_q    <= '0;
            of_cnt_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_int_q   <= res_int_d;
            res_uf_q    <= res_uf_d;
            res_of_q    <= res_of_d;
            uf_cnt_q    <= uf_cnt_d;
            of_cnt_q    <= of_cnt_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_int   = res_int_q;
    assign res_uf    = res_uf_q;
    assign res_of    = res_of_q;
    assign uf_cnt    = uf_cnt_q;
    assign of_cnt    = of_cnt_q;

endmodule

// File: doc/fp_conv_arbiter.md
Name: fp_conv_arbiter

Overview:
Shares one combinational 13-bit float to 8-bit integer converter (fp_to_int) among N_REQ requesters. Each requester uses a valid/ready handshake. A round-robin arbiter grants one request per cycle, converts it, and stores the result with the requester ID in a single output register. Saturating underflow/overflow event counters sit alongside for software status reads.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of res_id; must be >= clog2(N_REQ)
CNT_W, 16, width of each event counter

Ports:
clk  input  1  system clock, all logic on the rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-requester request valid
req_fp  input  13*N_REQ  packed operands; requester i uses bits [13*i+12:13*i]; format {sign, exp[3:0], frac[7:0]}
req_ready  output  N_REQ  one-hot grant/accept strobe
res_valid  output  1  result register holds valid data
res_ready  input  1  consumer accepts the result
res_id  output  ID_W  index of the requester that produced the result
res_int  output  8  sign-magnitude integer {sign, mag[6:0]}
res_uf  output  1  underflow flag for this result
res_of  output  1  overflow flag for this result
clr_cnt  input  1  synchronous clear of both event counters
uf_cnt  output  CNT_W  count of accepted underflow conversions
of_cnt  output  CNT_W  count of accepted overflow conversions

Behaviour:
- Reset values: res_valid=0, res_id=0, res_int=0, res_uf=0, res_of=0, uf_cnt=0, of_cnt=0, rr_ptr=0. req_ready=0 while reset is high.
- accept_en = !res_valid | res_ready. This gives a 1-deep pipeline with full throughput: back-to-back accepts are allowed while the consumer drains every cycle.
- Arbitration is combinational. Search req_valid starting at index rr_ptr and wrap upward mod N_REQ. The first asserted index g is the grant. req_ready[g] = accept_en. All other bits of req_ready are 0. No valid request means req_ready is all 0.
- req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- A transfer occurs when req_valid[g] & req_ready[g]. On that edge:
  - res_* load the conversion of req_fp[g] and res_id=g.
  - res_valid=1.
  - rr_ptr = (g+1) mod N_REQ.
- If there is no transfer and res_ready=1, then res_valid=0. If there is no transfer and res_ready=0, res_* hold their values.
- A request held without grant keeps its place. Fairness: a continuously valid requester waits at most N_REQ-1 accepted transfers.
- Conversion rule (priority order), on operand {s,e,f}:
  1. f==0: mag=0, uf=0, of=0.
  2. e==0: mag=0, uf=1.
  3. e>7: mag=7'h7F, of=1.
  4. Otherwise mag = (f >> (8-e))[6:0].
  - In all cases res_int = {s, mag}. Negative zero (s=1, f=0) gives 8'h80.
- Latency: 1 cycle from accepting edge to res_valid high.
- Counters:
  - On a transfer whose result has uf=1, uf_cnt increments. On a transfer whose result has of=1, of_cnt increments.
  - Both counters saturate at all-ones; no wrap.
  - clr_cnt has priority over a same-cycle increment; the counter becomes 0.
  - Reset has priority over everything.
- Reset asserted mid-operation: a pending result is discarded (res_valid=0 next edge), and a request presented in that cycle is not accepted.

Test Plan:
- Single request: req 0 sends {0,4'd3,8'hA0} with res_ready=1 -> one cycle later res_valid=1, res_id=0, res_int=8'h05, uf=0, of=0.
- Conversion corners on req 1:
  - {1,4'd4,8'hC0} -> 8'h8C.
  - {0,4'd7,8'hFF} -> 8'h7F.
  - {1,4'd9,8'h01} -> 8'hFF with of=1.
  - {0,4'd0,8'h80} -> 8'h00 with uf=1.
  - {1,4'd5,8'h00} -> 8'h80 with no flags.
- Round-robin: all 4 requesters valid continuously with res_ready=1 -> res_id sequence 0,1,2,3,0,... with one accept per cycle and no requester skipped.
- Backpressure: res_ready=0 for 3 cycles with result held -> req_ready stays 0 and res_* stay stable. When res_ready=1 on the next cycle, a new accept happens in that same cycle.
- Counters: 3 overflow and 2 underflow transfers -> of_cnt=3, uf_cnt=2. Then assert clr_cnt in the same cycle as an overflow transfer -> of_cnt=0. With CNT_W forced to 2, 5 overflow transfers leave of_cnt=3.
- Reset while res_valid=1 and req_valid=4'b1111 -> next edge res_valid=0, counters 0, rr_ptr=0. The first grant after release goes to requester 0.
